// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types and segment constants for the SRAM arbiter
package sram_arbiter_pkg;
  typedef logic [31:0] vaddr_t;
  typedef logic [31:0] paddr_t;
  typedef enum logic [1:0] {RESP_NONE, RESP_INST, RESP_DATA} resp_e;
  localparam logic [3:0] SEG_KSEG0_0 = 4'h8;
  localparam logic [3:0] SEG_KSEG0_1 = 4'h9;
  localparam logic [3:0] SEG_KSEG1_0 = 4'hA;
  localparam logic [3:0] SEG_KSEG1_1 = 4'hB;
endpackage

// File: rtl/sram_arbiter_xlate.sv
// addr_xlate: folds kseg0/kseg1 virtual addresses onto physical space; vaddr_i in, paddr_o out
module addr_xlate
  import sram_arbiter_pkg::*;
#(
  parameter bit XLATE_EN = 1'b1
) (
  input  vaddr_t vaddr_i,
  output paddr_t paddr_o
);
  logic [3:0] seg;
  logic       unmapped;
  always_comb begin
    seg      = vaddr_i[31:28];
    unmapped = seg inside {SEG_KSEG0_0, SEG_KSEG0_1, SEG_KSEG1_0, SEG_KSEG1_1};
    // low bit of the segment selects physical segment 0 or 1
    paddr_o  = (XLATE_EN && unmapped) ? {3'b000, seg[0], vaddr_i[27:0]} : vaddr_i;
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one synchronous SRAM port between an inst and a data requester
//   i_*/d_*  : requester handshakes (valid/addr_ok in, data_ok/rdata one cycle later)
//   sram_*   : SRAM port, rdata valid one cycle after sram_en
//   conflict_cnt : cycles in which both requesters were valid
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter bit PRIO_MODE = 1'b0,
  parameter bit XLATE_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_strobe,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [31:0] conflict_cnt
);
  resp_e       state_q, state_d;
  logic        fav_d_q, fav_d_d;
  logic [31:0] cnt_q, cnt_d;
  logic        conflict, grant_i, grant_d;
  paddr_t      i_paddr, d_paddr;
  addr_xlate #(.XLATE_EN(XLATE_EN)) u_xlate_i (.vaddr_i(i_addr), .paddr_o(i_paddr));
  addr_xlate #(.XLATE_EN(XLATE_EN)) u_xlate_d (.vaddr_i(d_addr), .paddr_o(d_paddr));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RESP_NONE;
      fav_d_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fav_d_q <= fav_d_d;
      cnt_q   <= cnt_d;
    end
  end
  // resetn gates grants so nothing is accepted while reset is held
  always_comb begin
    conflict = resetn && i_valid && d_valid;
    grant_d  = resetn && d_valid && (!i_valid || PRIO_MODE || fav_d_q);
    grant_i  = resetn && i_valid && !grant_d;
    state_d  = grant_i ? RESP_INST : grant_d ? RESP_DATA : RESP_NONE;
    // the loser of a conflict is favoured next time
    fav_d_d  = conflict ? grant_i : fav_d_q;
    cnt_d    = cnt_q + {31'd0, conflict};
  end
  always_comb begin
    i_addr_ok    = grant_i;
    d_addr_ok    = grant_d;
    sram_en      = grant_i || grant_d;
    sram_wen     = grant_d ? d_strobe : 4'h0;
    sram_addr    = grant_d ? d_paddr : i_paddr;
    sram_wdata   = grant_d ? d_wdata : 32'h0;
    i_data_ok    = state_q == RESP_INST;
    d_data_ok    = state_q == RESP_DATA;
    i_rdata      = i_data_ok ? sram_rdata : 32'h0;
    d_rdata      = d_data_ok ? sram_rdata : 32'h0;
    conflict_cnt = cnt_q;
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: three arbiter configurations on shared stimulus, checked against a bench model
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, d_valid;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_strobe;
  logic [31:0] sram_rdata = 32'h0;
  logic        i_addr_ok[3], i_data_ok[3], d_addr_ok[3], d_data_ok[3], sram_en[3];
  logic [31:0] i_rdata[3], d_rdata[3], sram_addr[3], sram_wdata[3], conflict_cnt[3];
  logic [3:0]  sram_wen[3];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] addr_tab[7] = '{32'h0000_1234, 32'h8000_0100, 32'h9FFF_FFFC, 32'hA123_4560,
                               32'hB000_0008, 32'hC000_0000, 32'h7FFF_FFF0};

  always #5 clk = ~clk;
  always @(posedge clk) sram_rdata <= $urandom;

  // instance 0: round-robin + xlate, 1: data priority + xlate, 2: round-robin, no xlate
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_arbiter #(.PRIO_MODE(g == 1), .XLATE_EN(g != 2)) dut (
      .clk(clk), .resetn(resetn),
      .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok[g]),
      .i_data_ok(i_data_ok[g]), .i_rdata(i_rdata[g]),
      .d_valid(d_valid), .d_addr(d_addr), .d_strobe(d_strobe), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok[g]), .d_data_ok(d_data_ok[g]), .d_rdata(d_rdata[g]),
      .sram_en(sram_en[g]), .sram_wen(sram_wen[g]), .sram_addr(sram_addr[g]),
      .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // kseg0/kseg1 are the windows 0x8000_0000..0xBFFF_FFFF, both folded onto the low 512 MB
  function automatic logic [31:0] phys(input int k, input logic [31:0] a);
    if (k != 2 && a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  int          m_pend[3];
  bit          m_fav_d[3];
  logic [31:0] m_cnt[3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int w;
      if (!resetn) begin
        m_pend[k] = 0;
        m_fav_d[k] = 1'b0;
        m_cnt[k] = 0;
        w = 0;
      end else if (i_valid && d_valid) w = (k == 1 || m_fav_d[k]) ? 2 : 1;
      else w = i_valid ? 1 : d_valid ? 2 : 0;
      chk("i_addr_ok", k, i_addr_ok[k], w == 1);
      chk("d_addr_ok", k, d_addr_ok[k], w == 2);
      chk("sram_en", k, sram_en[k], w != 0);
      if (w != 0) begin
        chk("sram_addr", k, sram_addr[k], phys(k, w == 1 ? i_addr : d_addr));
        chk("sram_wen", k, sram_wen[k], w == 2 ? d_strobe : 4'h0);
        chk("sram_wdata", k, sram_wdata[k], w == 2 ? d_wdata : 32'h0);
      end
      chk("i_data_ok", k, i_data_ok[k], m_pend[k] == 1);
      chk("d_data_ok", k, d_data_ok[k], m_pend[k] == 2);
      chk("i_rdata", k, i_rdata[k], m_pend[k] == 1 ? sram_rdata : 32'h0);
      chk("d_rdata", k, d_rdata[k], m_pend[k] == 2 ? sram_rdata : 32'h0);
      chk("conflict_cnt", k, conflict_cnt[k], m_cnt[k]);
      if (resetn) begin
        if (i_valid && d_valid) begin
          m_cnt[k] = m_cnt[k] + 1;
          m_fav_d[k] = (w == 1);
        end
        m_pend[k] = w;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
    i_addr = 0; d_addr = 0; d_strobe = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    nxt(); resetn = 1'b1; i_valid = 1'b1; i_addr = 32'hBFC0_0000;
    smp();
    chk("boot_addr_ok", 0, i_addr_ok[0], 1'b1);
    chk("boot_xlate", 0, sram_addr[0], 32'h1FC0_0000);
    chk("boot_noxlate", 2, sram_addr[2], 32'hBFC0_0000);
    nxt(); i_addr = 32'h9000_0004;
    smp();
    chk("boot_data_ok", 0, i_data_ok[0], 1'b1);
    chk("boot_rdata", 0, i_rdata[0], sram_rdata);
    chk("seg9_noxlate", 2, sram_addr[2], 32'h9000_0004);
    chk("seg9_xlate", 0, sram_addr[0], 32'h1000_0004);
    nxt(); i_valid = 1'b0; d_valid = 1'b1; d_addr = 32'h8000_0010;
    d_strobe = 4'hF; d_wdata = 32'hDEAD_BEEF;
    smp();
    chk("wr_addr_ok", 0, d_addr_ok[0], 1'b1);
    chk("wr_wen", 0, sram_wen[0], 4'hF);
    chk("wr_addr", 0, sram_addr[0], 32'h0000_0010);
    chk("wr_wdata", 0, sram_wdata[0], 32'hDEAD_BEEF);
    nxt(); d_valid = 1'b0; d_strobe = 4'h0;
    smp();
    chk("wr_data_ok", 0, d_data_ok[0], 1'b1);
    nxt(); resetn = 1'b0; i_valid = 1'b1; d_valid = 1'b1;
    i_addr = 32'h0000_1000; d_addr = 32'hA000_2000;
    smp();
    chk("rst_i_addr_ok", 0, i_addr_ok[0], 1'b0);
    chk("rst_d_addr_ok", 0, d_addr_ok[0], 1'b0);
    chk("rst_sram_en", 0, sram_en[0], 1'b0);
    nxt(); resetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      smp();
      chk("rr_i_grant", 0, i_addr_ok[0], (n % 2) == 0);
      chk("rr_d_grant", 0, d_addr_ok[0], (n % 2) == 1);
      chk("prio_d_grant", 1, d_addr_ok[1], 1'b1);
      chk("prio_i_wait", 1, i_addr_ok[1], 1'b0);
      nxt();
    end
    d_valid = 1'b0;
    smp();
    chk("rr_cnt", 0, conflict_cnt[0], 32'd4);
    chk("prio_cnt", 1, conflict_cnt[1], 32'd4);
    chk("prio_i_now", 1, i_addr_ok[1], 1'b1);
    nxt(); i_addr = 32'h0000_0040;
    smp();
    chk("pre_rst_grant", 0, i_addr_ok[0], 1'b1);
    nxt(); resetn = 1'b0; i_valid = 1'b0;
    smp();
    chk("rst_no_data_ok", 0, i_data_ok[0], 1'b0);
    chk("rst_cnt", 0, conflict_cnt[0], 32'd0);
    nxt(); resetn = 1'b1;
    repeat (3) begin
      smp();
      chk("post_rst_no_data_ok", 0, i_data_ok[0], 1'b0);
      nxt();
    end
    for (int n = 0; n < 80; n++) begin
      resetn = $urandom_range(0, 29) != 0;
      i_valid = $urandom_range(0, 2) != 0;
      d_valid = $urandom_range(0, 2) != 0;
      i_addr = addr_tab[$urandom_range(0, 6)];
      d_addr = addr_tab[$urandom_range(0, 6)];
      d_strobe = 4'($urandom);
      d_wdata = $urandom;
      nxt();
    end
    resetn = 1'b1; i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
